// File: rtl/sdram_refresh_scheduler.sv
// sdram_refresh_scheduler: defers SDRAM auto-refresh behind host traffic until the pending count becomes urgent
module sdram_refresh_scheduler #(
  parameter int TRP_CYC   = 3,
  parameter int TRFC_CYC  = 9,
  parameter int MAX_PEND  = 8,
  parameter int URGENT_TH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ref_int,
  input  logic       host_req,
  input  logic       host_busy,
  output logic       host_gnt,
  output logic       cmd_valid,
  output logic [1:0] cmd,
  output logic       refresh_active,
  output logic [3:0] pend_cnt,
  output logic       overflow
);
  typedef enum logic [2:0] {IDLE, PRECH, WAIT_RP, AREF, WAIT_RFC} state_t;
  localparam logic [3:0] RP_LOAD  = 4'(TRP_CYC - 2);
  localparam logic [3:0] RFC_LOAD = 4'(TRFC_CYC - 2);
  localparam logic [3:0] MAX      = 4'(MAX_PEND);
  localparam logic [3:0] URG      = 4'(URGENT_TH);
  state_t     state;
  logic [3:0] wait_cnt;
  logic       start_ref;
  assign start_ref = state == IDLE && pend_cnt != 4'd0 && !host_busy && (!host_req || pend_cnt >= URG);
  assign host_gnt  = state == IDLE && host_req && !start_ref;
  // Wait counters load N-2 so the PRECH/AREF cycle plus the wait span exactly N cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wait_cnt       <= 4'd0;
      cmd            <= 2'b00;
      cmd_valid      <= 1'b0;
      refresh_active <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_ref) begin
          state          <= PRECH;
          cmd            <= 2'b01;
          cmd_valid      <= 1'b1;
          refresh_active <= 1'b1;
        end
        PRECH: begin
          state    <= WAIT_RP;
          wait_cnt <= RP_LOAD;
          cmd      <= 2'b00;
        end
        WAIT_RP: if (wait_cnt == 4'd0) begin
          state <= AREF;
          cmd   <= 2'b10;
        end else wait_cnt <= wait_cnt - 4'd1;
        AREF: begin
          state    <= WAIT_RFC;
          wait_cnt <= RFC_LOAD;
          cmd      <= 2'b00;
        end
        WAIT_RFC: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        else if (pend_cnt >= URG) begin
          state <= AREF;
          cmd   <= 2'b10;
        end else begin
          state          <= IDLE;
          cmd_valid      <= 1'b0;
          refresh_active <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          wait_cnt       <= 4'd0;
          cmd            <= 2'b00;
          cmd_valid      <= 1'b0;
          refresh_active <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_cnt <= 4'd0;
      overflow <= 1'b0;
    end else if (ref_int && state != AREF) begin
      if (pend_cnt == MAX) overflow <= 1'b1;
      else pend_cnt <= pend_cnt + 4'd1;
    end else if (!ref_int && state == AREF && pend_cnt != 4'd0) pend_cnt <= pend_cnt - 4'd1;
  end
endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// tb_sdram_refresh_scheduler: directed scenarios with hand-computed cycle timing
module tb_sdram_refresh_scheduler;
  logic       clk = 1'b0;
  logic       reset_n, ref_int, host_req, host_busy;
  logic       host_gnt, cmd_valid, refresh_active, overflow;
  logic [1:0] cmd;
  logic [3:0] pend_cnt;
  int checks = 0;
  int errors = 0;

  sdram_refresh_scheduler dut (
    .clk(clk), .reset_n(reset_n), .ref_int(ref_int), .host_req(host_req), .host_busy(host_busy),
    .host_gnt(host_gnt), .cmd_valid(cmd_valid), .cmd(cmd), .refresh_active(refresh_active),
    .pend_cnt(pend_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && !(refresh_active == 1'b0 && pend_cnt == 4'd0); i++) tick();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ref_int = 1'b0; host_req = 1'b0; host_busy = 1'b0;
    repeat (3) tick();
    #1;
    checks++;
    if ({cmd, cmd_valid, refresh_active, pend_cnt, overflow, host_gnt} !== 10'd0) begin
      $display("FAIL reset_outputs: got %b expected 0", {cmd, cmd_valid, refresh_active, pend_cnt, overflow, host_gnt});
      errors++;
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_idle_refresh();
    ref_int = 1'b1;
    tick();
    ref_int = 1'b0;
    #1;
    checks++;
    if (pend_cnt !== 4'd1 || cmd_valid !== 1'b0) begin
      $display("FAIL idle_pend: got pend=%0d valid=%b expected pend=1 valid=0", pend_cnt, cmd_valid);
      errors++;
    end
    tick();
    checks++;
    if (cmd !== 2'b01 || cmd_valid !== 1'b1 || refresh_active !== 1'b1) begin
      $display("FAIL idle_prech: got cmd=%b valid=%b act=%b expected 01 1 1", cmd, cmd_valid, refresh_active);
      errors++;
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (cmd !== 2'b00 || cmd_valid !== 1'b1) begin
        $display("FAIL idle_wait_rp: got cmd=%b valid=%b expected 00 1", cmd, cmd_valid);
        errors++;
      end
    end
    tick();
    checks++;
    if (cmd !== 2'b10 || pend_cnt !== 4'd1) begin
      $display("FAIL idle_aref: got cmd=%b pend=%0d expected 10 1", cmd, pend_cnt);
      errors++;
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (cmd !== 2'b00 || cmd_valid !== 1'b1 || pend_cnt !== 4'd0) begin
        $display("FAIL idle_wait_rfc: got cmd=%b valid=%b pend=%0d expected 00 1 0", cmd, cmd_valid, pend_cnt);
        errors++;
      end
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || refresh_active !== 1'b0) begin
      $display("FAIL idle_return: got valid=%b act=%b expected 0 0", cmd_valid, refresh_active);
      errors++;
    end
  endtask

  task automatic test_deferral();
    host_req = 1'b1;
    ref_int = 1'b1;
    tick();
    tick();
    ref_int = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (host_gnt !== 1'b1 || cmd_valid !== 1'b0 || pend_cnt !== 4'd2) begin
        $display("FAIL defer_hold: got gnt=%b valid=%b pend=%0d expected 1 0 2", host_gnt, cmd_valid, pend_cnt);
        errors++;
      end
      tick();
    end
    host_req = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 1'b0) begin
      $display("FAIL defer_gnt_drop: got %b expected 0", host_gnt);
      errors++;
    end
    tick();
    checks++;
    if (cmd !== 2'b01 || cmd_valid !== 1'b1) begin
      $display("FAIL defer_prech: got cmd=%b valid=%b expected 01 1", cmd, cmd_valid);
      errors++;
    end
    drain();
    checks++;
    if (pend_cnt !== 4'd0 || refresh_active !== 1'b0) begin
      $display("FAIL defer_drain: got pend=%0d act=%b expected 0 0", pend_cnt, refresh_active);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    host_req = 1'b1;
    ref_int = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (pend_cnt !== 4'(i) || host_gnt !== 1'b1) begin
        $display("FAIL urg_ramp: got pend=%0d gnt=%b expected %0d 1", pend_cnt, host_gnt, i);
        errors++;
      end
      tick();
    end
    ref_int = 1'b0;
    #1;
    checks++;
    if (pend_cnt !== 4'd4 || host_gnt !== 1'b0) begin
      $display("FAIL urg_gnt_drop: got pend=%0d gnt=%b expected 4 0", pend_cnt, host_gnt);
      errors++;
    end
    tick();
    checks++;
    if (cmd !== 2'b01) begin
      $display("FAIL urg_prech: got cmd=%b expected 01", cmd);
      errors++;
    end
    repeat (3) tick();
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (cmd !== 2'b10 || pend_cnt !== 4'd4) begin
        $display("FAIL urg_aref%0d: got cmd=%b pend=%0d expected 10 4", k, cmd, pend_cnt);
        errors++;
      end
      for (int j = 1; j <= 8; j++) begin
        tick();
        ref_int = (k < 4 && j == 1);
        #1;
        checks++;
        if (cmd !== 2'b00 || cmd_valid !== 1'b1) begin
          $display("FAIL urg_wait_rfc%0d: got cmd=%b valid=%b expected 00 1", k, cmd, cmd_valid);
          errors++;
        end
      end
      tick();
      ref_int = 1'b0;
    end
    #1;
    checks++;
    if (refresh_active !== 1'b0 || pend_cnt !== 4'd3 || host_gnt !== 1'b1) begin
      $display("FAIL urg_exit: got act=%b pend=%0d gnt=%b expected 0 3 1", refresh_active, pend_cnt, host_gnt);
      errors++;
    end
    host_req = 1'b0;
    drain();
    checks++;
    if (pend_cnt !== 4'd0 || refresh_active !== 1'b0) begin
      $display("FAIL urg_drain: got pend=%0d act=%b expected 0 0", pend_cnt, refresh_active);
      errors++;
    end
  endtask

  task automatic test_saturation();
    host_busy = 1'b1;
    ref_int = 1'b1;
    repeat (8) tick();
    #1;
    checks++;
    if (pend_cnt !== 4'd8 || overflow !== 1'b0 || cmd_valid !== 1'b0) begin
      $display("FAIL sat_full: got pend=%0d ovf=%b valid=%b expected 8 0 0", pend_cnt, overflow, cmd_valid);
      errors++;
    end
    tick();
    ref_int = 1'b0;
    #1;
    checks++;
    if (pend_cnt !== 4'd8 || overflow !== 1'b1 || host_gnt !== 1'b0) begin
      $display("FAIL sat_overflow: got pend=%0d ovf=%b gnt=%b expected 8 1 0", pend_cnt, overflow, host_gnt);
      errors++;
    end
    host_busy = 1'b0;
    repeat (4) tick();
    ref_int = 1'b1;
    #1;
    checks++;
    if (cmd !== 2'b10 || pend_cnt !== 4'd8) begin
      $display("FAIL sat_aref: got cmd=%b pend=%0d expected 10 8", cmd, pend_cnt);
      errors++;
    end
    tick();
    ref_int = 1'b0;
    #1;
    checks++;
    if (pend_cnt !== 4'd8 || overflow !== 1'b1) begin
      $display("FAIL sat_coincident: got pend=%0d ovf=%b expected 8 1", pend_cnt, overflow);
      errors++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd, cmd_valid, refresh_active, pend_cnt, overflow} !== 9'd0) begin
      $display("FAIL sat_reset_clear: got %b expected 0", {cmd, cmd_valid, refresh_active, pend_cnt, overflow});
      errors++;
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_mid_reset();
    ref_int = 1'b1;
    tick();
    ref_int = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (cmd !== 2'b00 || cmd_valid !== 1'b1) begin
      $display("FAIL mid_in_wait_rp: got cmd=%b valid=%b expected 00 1", cmd, cmd_valid);
      errors++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd, cmd_valid, refresh_active, pend_cnt, overflow, host_gnt} !== 10'd0) begin
      $display("FAIL mid_reset: got %b expected 0", {cmd, cmd_valid, refresh_active, pend_cnt, overflow, host_gnt});
      errors++;
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b0 || refresh_active !== 1'b0 || pend_cnt !== 4'd0) begin
        $display("FAIL mid_stay_idle: got valid=%b act=%b pend=%0d expected 0 0 0", cmd_valid, refresh_active, pend_cnt);
        errors++;
      end
    end
  endtask

  task automatic test_busy_gate();
    host_busy = 1'b1;
    ref_int = 1'b1;
    repeat (5) tick();
    ref_int = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (cmd_valid !== 1'b0 || pend_cnt !== 4'd5) begin
        $display("FAIL busy_hold: got valid=%b pend=%0d expected 0 5", cmd_valid, pend_cnt);
        errors++;
      end
      tick();
    end
    host_busy = 1'b0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0) begin
      $display("FAIL busy_fall: got valid=%b expected 0", cmd_valid);
      errors++;
    end
    tick();
    host_busy = 1'b1;
    #1;
    checks++;
    if (cmd !== 2'b01) begin
      $display("FAIL busy_prech: got cmd=%b expected 01", cmd);
      errors++;
    end
    repeat (3) tick();
    #1;
    checks++;
    if (cmd !== 2'b10 || refresh_active !== 1'b1) begin
      $display("FAIL busy_no_abort: got cmd=%b act=%b expected 10 1", cmd, refresh_active);
      errors++;
    end
    host_busy = 1'b0;
    drain();
    checks++;
    if (pend_cnt !== 4'd0 || refresh_active !== 1'b0) begin
      $display("FAIL busy_drain: got pend=%0d act=%b expected 0 0", pend_cnt, refresh_active);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_deferral();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    test_busy_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
